// File: rtl/handshake_skid_if.sv
// handshake_skid_if: valid/ready/data channel; master drives valid and data, slave drives ready.
interface handshake_skid_if #(parameter int WIDTH = 32);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/handshake_skid.sv
// handshake_skid: two-entry register slice with registered valid/ready/data and an output-beat counter.
module handshake_skid #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    handshake_skid_if.slave   up,
    handshake_skid_if.master  dn,
    output logic [1:0]        level_o,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  beat_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t           state;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             ready_q, valid_q;
    logic             in_fire, out_fire;
    assign in_fire  = up.valid & ready_q;
    assign out_fire = valid_q & dn.ready;
    assign up.ready = ready_q;
    assign dn.valid = valid_q;
    assign dn.data  = main_q;
    assign level_o  = state;
    // main is zeroed whenever the buffer empties so data_o reads 0 while invalid
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: if (in_fire) begin
                    main_q  <= up.data;
                    state   <= BUSY;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= 1'b1;
                end
                BUSY: if (in_fire && out_fire) begin
                    main_q <= up.data;
                end else if (in_fire) begin
                    skid_q  <= up.data;
                    state   <= FULL;
                    ready_q <= 1'b0;
                end else if (out_fire) begin
                    main_q  <= '0;
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
                FULL: if (out_fire) begin
                    main_q  <= skid_q;
                    state   <= BUSY;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= EMPTY;
                    main_q  <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
    always_ff @(posedge clk)
        beat_cnt <= (!rstn || cnt_clr) ? '0 : beat_cnt + CNT_W'(out_fire);
endmodule

// File: tb/tb_handshake_skid.sv
// tb_handshake_skid: randomized bench comparing the skid buffer to a queue-based reference model.
module tb_handshake_skid;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [1:0]  level_o;
    logic [15:0] beat_cnt;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic        exp_rdy = 1'b0;
    logic [15:0] exp_cnt = '0;
    handshake_skid_if #(.WIDTH(32)) up ();
    handshake_skid_if #(.WIDTH(32)) dn ();
    handshake_skid #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .up(up.slave), .dn(dn.master),
        .level_o(level_o), .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // model: the buffer is a FIFO of depth 2 whose ready reflects occupancy as of the last edge
    task automatic step();
        logic inf, outf;
        inf  = up.valid && exp_rdy;
        outf = (exp_q.size() > 0) && dn.ready;
        @(posedge clk);
        if (!rstn) begin
            exp_q.delete();
            exp_rdy = 1'b0;
            exp_cnt = '0;
        end else begin
            if (outf) void'(exp_q.pop_front());
            if (inf) exp_q.push_back(up.data);
            exp_rdy = exp_q.size() < 2;
            exp_cnt = cnt_clr ? 16'h0 : exp_cnt + 16'(outf);
        end
        @(negedge clk);
        chk("ready", {31'b0, up.ready}, {31'b0, exp_rdy});
        chk("valid", {31'b0, dn.valid}, {31'b0, exp_q.size() > 0});
        chk("data", dn.data, exp_q.size() > 0 ? exp_q[0] : 32'h0);
        chk("level", {30'b0, level_o}, 32'(exp_q.size()));
        chk("cnt", {16'b0, beat_cnt}, {16'b0, exp_cnt});
    endtask
    initial begin
        up.valid = 1'b0;
        up.data  = '0;
        dn.ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        chk("rdy_low_after_rst", {31'b0, up.ready}, 32'h0);
        step();
        chk("rdy_high_after_idle", {31'b0, up.ready}, 32'h1);
        dn.ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            up.valid = 1'b1;
            up.data  = 32'(k);
            step();
            chk("stream_data", dn.data, 32'(k));
        end
        up.valid = 1'b0;
        step();
        chk("stream_cnt", {16'b0, beat_cnt}, 32'd8);
        dn.ready = 1'b0;
        up.valid = 1'b1;
        up.data  = 32'hA;
        step();
        up.data  = 32'hB;
        step();
        up.valid = 1'b0;
        step();
        chk("full_level", {30'b0, level_o}, 32'd2);
        chk("full_ready", {31'b0, up.ready}, 32'h0);
        chk("full_hold", dn.data, 32'hA);
        dn.ready = 1'b1;
        step();
        chk("drain_b", dn.data, 32'hB);
        step();
        chk("drain_empty", {30'b0, level_o}, 32'd0);
        for (int i = 0; i < 10000; i++) begin
            up.valid = 1'($urandom_range(0, 1));
            up.data  = $urandom;
            dn.ready = 1'($urandom_range(0, 1));
            cnt_clr  = ($urandom_range(0, 63) == 0);
            step();
            if (level_o == 2'd2) chk("no_accept_full", {31'b0, up.ready}, 32'h0);
        end
        cnt_clr  = 1'b0;
        up.valid = 1'b0;
        dn.ready = 1'b1;
        step();
        step();
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        up.valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            up.data = 32'(i);
            step();
        end
        up.valid = 1'b0;
        step();
        chk("cnt_ffff", {16'b0, beat_cnt}, 32'hFFFF);
        up.valid = 1'b1;
        step();
        up.valid = 1'b0;
        step();
        chk("cnt_wrap", {16'b0, beat_cnt}, 32'h0);
        up.valid = 1'b1;
        up.data  = 32'h55;
        step();
        step();
        chk("cnt_one", {16'b0, beat_cnt}, 32'h1);
        up.valid = 1'b0;
        cnt_clr  = 1'b1;
        step();
        cnt_clr  = 1'b0;
        chk("clr_wins", {16'b0, beat_cnt}, 32'h0);
        step();
        dn.ready = 1'b0;
        up.valid = 1'b1;
        up.data  = 32'hDEAD0001;
        step();
        up.data  = 32'hDEAD0002;
        step();
        chk("pre_rst_level", {30'b0, level_o}, 32'd2);
        rstn     = 1'b0;
        dn.ready = 1'b1;
        step();
        chk("rst_valid", {31'b0, dn.valid}, 32'h0);
        chk("rst_level", {30'b0, level_o}, 32'd0);
        rstn     = 1'b1;
        up.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("discarded", dn.data, 32'h0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
